adc_capture_mc: RTL and testbench

//  Multi-channel successor to the single-channel ADC capture driver. Decimates packed ADC samples,

---
 rtl/adc_capture_mc_pkg.sv | 17 +
 rtl/adc_capture_mc_trig_detect.sv | 59 +++++
 rtl/adc_capture_mc.sv | 205 ++++++++++++++++++++
 tb/tb_adc_capture_mc.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_mc_pkg.sv
// Shared types for the multi-channel ADC capture block: FSM state encoding and capture modes.
package adc_capture_mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_AUTO   = 2'd2;
  localparam logic [1:0] MODE_FREE   = 2'd3;

endpackage

// File: rtl/adc_capture_mc_trig_detect.sv
// Trigger detector: selects the source channel, keeps the previous strobe sample and
// reports a one-clock hit on the strobe where the level (or external edge) is crossed.
module adc_capture_mc_trig_detect #(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 8,
  parameter int TCW      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       strobe,
  input  logic [CHANNELS*DATA_W-1:0] adc_data,
  input  logic [TCW-1:0]             trig_ch,
  input  logic [DATA_W-1:0]          trig_level,
  input  logic                       trig_falling,
  input  logic                       trig_ext,
  input  logic                       trig_src,
  output logic                       hit
);

  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic              prev_ext;
  logic              lvl_hit;
  logic              ext_hit;

  always_comb begin
    cur = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(trig_ch) == i) cur = adc_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    lvl_hit = 1'b0;
    if (trig_falling) lvl_hit = (prev > trig_level) && (cur <= trig_level);
    else              lvl_hit = (prev < trig_level) && (cur >= trig_level);
  end

  assign ext_hit = trig_ext && !prev_ext;
  assign hit     = strobe && prev_valid && (trig_src ? ext_hit : lvl_hit);

  // The previous sample is invalidated at every capture start so no trigger fires on the first strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      prev_ext   <= 1'b0;
    end else if (clear) begin
      prev_valid <= 1'b0;
    end else if (strobe) begin
      prev       <= cur;
      prev_ext   <= trig_ext;
      prev_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/adc_capture_mc.sv
// Multi-channel ADC capture: decimation, circular buffer writes, level trigger with pre-trigger depth.
// Optional external trigger input enabled by defining ADC_EXT_TRIG_EN.
module adc_capture_mc
  import adc_capture_mc_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 10,
  parameter int DEL_W    = 24,
  localparam int TCW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int SW      = CHANNELS * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW-1:0]     adc_data,
  input  logic [DEL_W-1:0]  sample_divider,
  input  logic [1:0]        mode,
  input  logic              arm,
  input  logic [TCW-1:0]    trig_ch,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_falling,
  input  logic [DEPTH-1:0]  pretrig_len,
`ifdef ADC_EXT_TRIG_EN
  input  logic              trig_ext,
  input  logic              trig_src,
`endif
  input  logic              ready,
  output logic              valid,
  output logic [DEPTH-1:0]  mem_addr,
  output logic [SW-1:0]     mem_data,
  output logic              mem_en,
  output logic [DEPTH-1:0]  trig_addr,
  output logic              waiting_for_trigger,
  output logic              triggered,
  output logic              forced,
  output logic [2:0]        dbg_state
);

  // Handshake: valid rises when the buffer is complete and stays high until a clock
  // where valid && ready are both high; that clock completes the transfer.

  state_t             state;
  logic [1:0]         mode_s;
  logic [DEL_W-1:0]   div_s;
  logic [TCW-1:0]     ch_s;
  logic [DATA_W-1:0]  level_s;
  logic               fall_s;
  logic [DEPTH-1:0]   pre_s;

  logic [DEL_W-1:0]   presc;
  logic [DEPTH-1:0]   addr;
  logic [DEPTH-1:0]   pre_cnt;
  logic [DEPTH-1:0]   armed_cnt;
  logic [DEPTH-1:0]   post_left;

  logic running;
  logic draining;
  logic strobe;
  logic handshake;
  logic start;
  logic det_hit;
  logic det_ext;
  logic det_src;
  logic trig_hit;
  logic auto_timeout;

  assign running   = (state == ST_PRE) || (state == ST_ARMED) || (state == ST_POST);
  // After the last POST sample one clock is spent with strobes masked so that the
  // final write completes before DONE.
  assign draining  = (state == ST_POST) && (post_left == '0);
  assign strobe    = running && !draining && (presc == div_s);
  assign handshake = (state == ST_DONE) && valid && ready;
  assign start     = ((state == ST_IDLE) && arm) ||
                     (handshake && (mode_s inside {MODE_NORMAL, MODE_AUTO, MODE_FREE}));

  assign trig_hit     = (mode_s == MODE_FREE) || det_hit;
  assign auto_timeout = (mode_s == MODE_AUTO) && (&armed_cnt);

  assign waiting_for_trigger = (state == ST_ARMED);
  assign dbg_state           = state;

`ifdef ADC_EXT_TRIG_EN
  logic src_s;

  always_ff @(posedge clk) begin
    if (rst)        src_s <= 1'b0;
    else if (start) src_s <= trig_src;
  end

  assign det_ext = trig_ext;
  assign det_src = src_s;
`else
  assign det_ext = 1'b0;
  assign det_src = 1'b0;
`endif

  adc_capture_mc_trig_detect #(
    .CHANNELS (CHANNELS),
    .DATA_W   (DATA_W),
    .TCW      (TCW)
  ) u_trig (
    .clk          (clk),
    .rst          (rst),
    .clear        (start),
    .strobe       (strobe),
    .adc_data     (adc_data),
    .trig_ch      (ch_s),
    .trig_level   (level_s),
    .trig_falling (fall_s),
    .trig_ext     (det_ext),
    .trig_src     (det_src),
    .hit          (det_hit)
  );

  always_ff @(posedge clk) begin
    if (rst)                  presc <= '0;
    else if (!running)        presc <= '0;
    else if (presc == div_s)  presc <= '0;
    else                      presc <= presc + DEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_s    <= MODE_SINGLE;
      div_s     <= '0;
      ch_s      <= '0;
      level_s   <= '0;
      fall_s    <= 1'b0;
      pre_s     <= '0;
      addr      <= '0;
      pre_cnt   <= '0;
      armed_cnt <= '0;
      post_left <= '0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_en    <= 1'b0;
      trig_addr <= '0;
      triggered <= 1'b0;
      forced    <= 1'b0;
      valid     <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      if (strobe) begin
        mem_en   <= 1'b1;
        mem_data <= adc_data;
        mem_addr <= addr;
        addr     <= addr + DEPTH'(1);
      end

      case (state)
        ST_PRE: begin
          if (strobe) begin
            if (pre_cnt == pre_s - DEPTH'(1)) state <= ST_ARMED;
            pre_cnt <= pre_cnt + DEPTH'(1);
          end
        end
        ST_ARMED: begin
          if (strobe) begin
            if (trig_hit || auto_timeout) begin
              state     <= ST_POST;
              trig_addr <= addr;
              triggered <= 1'b1;
              forced    <= !trig_hit;
              // The trigger sample is the first of 2**DEPTH - pre_s post samples.
              post_left <= ~pre_s;
            end else begin
              armed_cnt <= armed_cnt + DEPTH'(1);
            end
          end
        end
        ST_POST: begin
          if (draining) begin
            state <= ST_DONE;
            valid <= 1'b1;
          end else if (strobe) begin
            post_left <= post_left - DEPTH'(1);
          end
        end
        ST_DONE: begin
          if (handshake) begin
            valid <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Capture start latches the configuration so later input changes do not disturb it.
      if (start) begin
        state     <= (pretrig_len == '0) ? ST_ARMED : ST_PRE;
        mode_s    <= mode;
        div_s     <= sample_divider;
        ch_s      <= trig_ch;
        level_s   <= trig_level;
        fall_s    <= trig_falling;
        pre_s     <= pretrig_len;
        pre_cnt   <= '0;
        armed_cnt <= '0;
        triggered <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_mc.sv
// Scoreboard bench for adc_capture_mc: directed captures, completion records checked by a monitor.
module tb_adc_capture_mc;
  import adc_capture_mc_pkg::*;

  localparam int CH    = 2;
  localparam int DW    = 8;
  localparam int DEP   = 6;
  localparam int DLW   = 8;
  localparam int EXP_W = 6 + 1 + 16 + 16 + 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [15:0]    adc_data;
  logic [DLW-1:0] sample_divider;
  logic [1:0]     mode;
  logic           arm;
  logic           trig_ch;
  logic [7:0]     trig_level;
  logic           trig_falling;
  logic [DEP-1:0] pretrig_len;
  logic           ready;
  logic           valid;
  logic [DEP-1:0] mem_addr;
  logic [15:0]    mem_data;
  logic           mem_en;
  logic [DEP-1:0] trig_addr;
  logic           waiting_for_trigger;
  logic           triggered;
  logic           forced;
  logic [2:0]     dbg_state;
`ifdef ADC_EXT_TRIG_EN
  logic           trig_ext;
  logic           trig_src;
`endif

  logic [7:0] ch0;
  logic [7:0] ch1;
  bit         ramp_en;
  bit         fall_en;
  assign adc_data = {ch1, ch0};

  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];

  adc_capture_mc #(
    .CHANNELS (CH),
    .DATA_W   (DW),
    .DEPTH    (DEP),
    .DEL_W    (DLW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .adc_data            (adc_data),
    .sample_divider      (sample_divider),
    .mode                (mode),
    .arm                 (arm),
    .trig_ch             (trig_ch),
    .trig_level          (trig_level),
    .trig_falling        (trig_falling),
    .pretrig_len         (pretrig_len),
`ifdef ADC_EXT_TRIG_EN
    .trig_ext            (trig_ext),
    .trig_src            (trig_src),
`endif
    .ready               (ready),
    .valid               (valid),
    .mem_addr            (mem_addr),
    .mem_data            (mem_data),
    .mem_en              (mem_en),
    .trig_addr           (trig_addr),
    .waiting_for_trigger (waiting_for_trigger),
    .triggered           (triggered),
    .forced              (forced),
    .dbg_state           (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary required");
    $fatal(1, "watchdog");
  end

  // Ramp source: advances once per written sample so each strobe sees the next value.
  always @(negedge clk) begin
    if (mem_en && ramp_en) begin
      ch0 = ch0 + 8'd1;
      if (fall_en) ch1 = ch1 - 8'd4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_arm;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse_ready;
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return valid;
      1:       return triggered;
      default: return waiting_for_trigger;
    endcase
  endfunction

  task automatic wait_for(input string name, input int sel, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig(sel) && n < budget);
    check(name, {31'd0, sig(sel)}, 32'd1);
  endtask

  task automatic wait_writes(input int count, input int budget);
    int seen = 0;
    int n = 0;
    while (seen < count && n < budget) begin
      @(negedge clk);
      n++;
      if (mem_en) seen++;
    end
    check("wait_writes", seen, count);
  endtask

  task automatic push_exp(input logic [5:0] taddr, input logic frc, input logic [15:0] total,
                          input logic [15:0] post, input logic [15:0] data);
    exp_q.push_back({taddr, frc, total, post, data});
  endtask

  // Scoreboard monitor: tracks writes and compares a completion record on each valid rise.
  logic [5:0]  exp_addr;
  logic [15:0] cnt_total;
  logic [15:0] cnt_post;
  logic [15:0] first_data;
  logic        valid_q;

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (rst) begin
      exp_addr  = '0;
      cnt_total = '0;
      cnt_post  = '0;
      first_data = '0;
      valid_q   = 1'b0;
    end else begin
      if (mem_en) begin
        check("mem_addr_seq", mem_addr, exp_addr);
        exp_addr = exp_addr + 6'd1;
        cnt_total = cnt_total + 16'd1;
        if (triggered) begin
          if (cnt_post == 16'd0) first_data = mem_data;
          cnt_post = cnt_post + 16'd1;
        end
      end
      if (dbg_state == ST_DONE) check("mem_en_in_done", mem_en, 0);
      if (valid && !valid_q) begin
        check("exp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("trig_addr", trig_addr, e[54:49]);
          check("forced", forced, e[48]);
          check("total_writes", cnt_total, e[47:32]);
          check("post_writes", cnt_post, e[31:16]);
          check("trig_sample", first_data, e[15:0]);
        end
        cnt_total = '0;
        cnt_post  = '0;
      end
      valid_q = valid;
    end
  end

  initial begin
    rst = 1'b1; arm = 1'b0; ready = 1'b0; mode = MODE_SINGLE;
    sample_divider = 8'd1; trig_ch = 1'b0; trig_level = 8'h30; trig_falling = 1'b0;
    pretrig_len = 6'd16; ch0 = 8'h00; ch1 = 8'h00; ramp_en = 1'b0; fall_en = 1'b0;
`ifdef ADC_EXT_TRIG_EN
    trig_ext = 1'b0; trig_src = 1'b0;
`endif
    tick();
    tick();
    @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_trig_addr", trig_addr, 0);
    check("rst_flags", {waiting_for_trigger, triggered, forced}, 0);
    check("rst_state", dbg_state, ST_IDLE);
    tick();
    rst = 1'b0;

    // 1: single capture, ramp on ch0, rising through 0x30 with 16 pre-trigger samples
    ramp_en = 1'b1;
    push_exp(6'd48, 1'b0, 16'd96, 16'd48, 16'h0030);
    pulse_arm();
    wait_for("t1_armed", 2, 200);
    wait_for("t1_valid", 0, 400);
    tick();
    pulse_ready();
    @(negedge clk);
    check("t1_valid_after_ready", valid, 0);
    check("t1_state_idle", dbg_state, ST_IDLE);
    check("t1_triggered_held", triggered, 1);

    // 2: normal mode, three back-to-back captures, ready 3 clk after valid
    mode = MODE_NORMAL;
    ch0  = 8'h00;
    push_exp(6'd16, 1'b0, 16'd96, 16'd48, 16'h0030);
    push_exp(6'd48, 1'b0, 16'd96, 16'd48, 16'h0030);
    push_exp(6'd16, 1'b0, 16'd96, 16'd48, 16'h0030);
    tick();
    pulse_arm();
    for (int k = 0; k < 3; k++) begin
      wait_for("t2_valid", 0, 400);
      tick();
      ch0 = 8'h00;
      tick();
      tick();
      pulse_ready();
      @(negedge clk);
      check("t2_rearm_state", dbg_state, ST_PRE);
      check("t2_rearm_triggered", triggered, 0);
      check("t2_rearm_valid", valid, 0);
    end

    // 3: auto mode, constant below level, forced trigger after 64 armed strobes
    ramp_en = 1'b0;
    do_reset();
    mode = MODE_AUTO;
    ch0  = 8'h10;
    push_exp(6'd15, 1'b1, 16'd127, 16'd48, 16'h0010);
    pulse_arm();
    wait_for("t3_valid", 0, 600);
    check("t3_forced_out", forced, 1);
    tick();
    pulse_ready();

    // 4: free-run, divider 0, pre-trigger depth 63 then 0
    do_reset();
    mode = MODE_FREE; sample_divider = 8'd0; pretrig_len = 6'd63;
    ch0 = 8'h5A; ch1 = 8'hA5;
    push_exp(6'd63, 1'b0, 16'd64, 16'd1, 16'hA55A);
    pulse_arm();
    wait_for("t4a_valid", 0, 300);
    tick();
    do_reset();
    pretrig_len = 6'd0;
    push_exp(6'd0, 1'b0, 16'd64, 16'd64, 16'hA55A);
    pulse_arm();
    wait_for("t4b_valid", 0, 300);
    tick();

    // 5: falling edge on ch1 while ch0 ramps; level changed during POST
    do_reset();
    mode = MODE_SINGLE; sample_divider = 8'd1; pretrig_len = 6'd4;
    trig_ch = 1'b1; trig_falling = 1'b1; trig_level = 8'h40;
    ch0 = 8'h00; ch1 = 8'h80; ramp_en = 1'b1; fall_en = 1'b1;
    push_exp(6'd16, 1'b0, 16'd76, 16'd60, 16'h4010);
    pulse_arm();
    wait_for("t5_trig", 1, 300);
    tick();
    trig_level = 8'h10;
    trig_ch    = 1'b0;
    wait_for("t5_valid", 0, 400);
    tick();
    pulse_ready();
    @(negedge clk);
    check("t5_state_idle", dbg_state, ST_IDLE);
    ramp_en = 1'b0; fall_en = 1'b0;

    // 6: reset in the middle of POST
    do_reset();
    mode = MODE_FREE; pretrig_len = 6'd5; ch0 = 8'h3C; ch1 = 8'hC3;
    pulse_arm();
    wait_for("t6_trig", 1, 200);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("t6_valid", valid, 0);
    check("t6_mem_en", mem_en, 0);
    check("t6_mem_addr", mem_addr, 0);
    check("t6_mem_data", mem_data, 0);
    check("t6_trig_addr", trig_addr, 0);
    check("t6_flags", {waiting_for_trigger, triggered, forced}, 0);
    check("t6_state", dbg_state, ST_IDLE);
    tick();
    rst = 1'b0;

`ifdef ADC_EXT_TRIG_EN
    // External trigger edge with the comparator unable to fire
    do_reset();
    mode = MODE_SINGLE; trig_src = 1'b1; pretrig_len = 6'd2; sample_divider = 8'd1;
    trig_ch = 1'b0; trig_falling = 1'b0; trig_level = 8'hFF; ch0 = 8'h77; ch1 = 8'h00;
    push_exp(6'd4, 1'b0, 16'd66, 16'd62, 16'h0077);
    pulse_arm();
    wait_writes(4, 100);
    tick();
    trig_ext = 1'b1;
    wait_for("ext_valid", 0, 300);
    tick();
    trig_ext = 1'b0;
    pulse_ready();
`endif

    tick();
    tick();
    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
